// File: rtl/int_dispatch_queue_pkg.sv
// Shared core types and sizing constants for the integer dispatch queue.
// intDQEntry_t is the renamed micro-op payload carried from rename to issue.
package int_dispatch_queue_pkg;

  localparam int INTDQ_SIZE     = 16;
  localparam int RENAME_WIDTH   = 4;
  localparam int INTDQ_DISP_WID = 4;

  typedef struct packed {
    logic [7:0] rob_idx;
    logic [5:0] prd;
    logic [5:0] prs1;
    logic [5:0] prs2;
    logic [5:0] uop;
  } intDQEntry_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/int_dispatch_queue_if.sv
// Rename-side and issue-side signal bundle of the integer dispatch queue.
// The queue binds to the slave modport; rename/issue (or a bench) to master.
interface int_dispatch_queue_if
  import int_dispatch_queue_pkg::*;
#(
  parameter int DEPTH       = INTDQ_SIZE,
  parameter int INPORT_NUM  = RENAME_WIDTH,
  parameter int OUTPORT_NUM = INTDQ_DISP_WID
) ();

  // Enqueue: when o_can_enq is high, every set bit of the prefix i_enq_req is
  // taken that edge; when it is low the whole group is dropped and must be
  // re-presented. Dequeue: o_deq_req[j] offers slot j, and only the leading run
  // of ones in (i_deq_vld & o_deq_req) is consumed at the edge.
  logic                                i_squash_vld;
  logic                                o_can_enq;
  logic        [INPORT_NUM-1:0]        i_enq_req;
  intDQEntry_t [INPORT_NUM-1:0]        i_enq_info;
  logic        [OUTPORT_NUM-1:0]       o_deq_req;
  intDQEntry_t [OUTPORT_NUM-1:0]       o_deq_info;
  logic        [OUTPORT_NUM-1:0]       i_deq_vld;
  logic        [$clog2(DEPTH):0]       o_count;

  modport slave (
    input  i_squash_vld, i_enq_req, i_enq_info, i_deq_vld,
    output o_can_enq, o_deq_req, o_deq_info, o_count
  );

  modport master (
    output i_squash_vld, i_enq_req, i_enq_info, i_deq_vld,
    input  o_can_enq, o_deq_req, o_deq_info, o_count
  );

endinterface

// File: rtl/int_dispatch_queue_ring_ptr.sv
// Circular-buffer pointer with a wrap bit in the MSB; advances by a small step
// and clears synchronously. Plain binary add wraps correctly for power-of-two depths.
module ring_ptr
  import int_dispatch_queue_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [STEP_W-1:0] inc_i,
  output logic [IDX_W:0]    ptr_o
);

  logic [IDX_W:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q + (IDX_W+1)'(inc_i);
    if (clr_i) ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/int_dispatch_queue.sv
// In-order integer dispatch queue: multi-port enqueue from rename, in-order
// prefix dequeue to issue, full flush on squash. Optional INT_DISPATCH_QUEUE_PERF_EN.
module int_dispatch_queue
  import int_dispatch_queue_pkg::*;
#(
  parameter int DEPTH       = INTDQ_SIZE,
  parameter int INPORT_NUM  = RENAME_WIDTH,
  parameter int OUTPORT_NUM = INTDQ_DISP_WID
) (
  input  logic                 clk,
  input  logic                 rst,
  int_dispatch_queue_if.slave  bus
`ifdef INT_DISPATCH_QUEUE_PERF_EN
  ,
  output logic [31:0]          o_perf_full_stall
`endif
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int MAX_N  = max_int(INPORT_NUM, OUTPORT_NUM);
  localparam int STEP_W = $clog2(MAX_N + 1);

  logic [CNT_W-1:0]  head_ptr, tail_ptr, count;
  logic [IDX_W-1:0]  head_idx, tail_idx;
  logic              can_enq, enq_fire;
  logic [STEP_W-1:0] enq_num, deq_num, tail_inc;
  logic              run;
  logic        [OUTPORT_NUM-1:0] deq_req;
  intDQEntry_t [OUTPORT_NUM-1:0] deq_info;
  intDQEntry_t mem_q [DEPTH];

  // Modular subtraction over the wrap-extended pointers yields 0..DEPTH.
  assign count    = tail_ptr - head_ptr;
  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign can_enq  = (count <= CNT_W'(DEPTH - INPORT_NUM));
  assign enq_fire = can_enq && !bus.i_squash_vld;
  assign tail_inc = enq_fire ? enq_num : '0;

  always_comb begin
    enq_num = '0;
    for (int i = 0; i < INPORT_NUM; i++) begin
      enq_num = enq_num + STEP_W'(bus.i_enq_req[i]);
    end
  end

  // Only the unbroken run of accepts from slot 0 is consumed.
  always_comb begin
    deq_num = '0;
    run     = 1'b1;
    for (int j = 0; j < OUTPORT_NUM; j++) begin
      run     = run & bus.i_deq_vld[j] & deq_req[j];
      deq_num = deq_num + STEP_W'(run);
    end
  end

  ring_ptr #(.IDX_W(IDX_W), .STEP_W(STEP_W)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.i_squash_vld),
    .inc_i (deq_num),
    .ptr_o (head_ptr)
  );

  ring_ptr #(.IDX_W(IDX_W), .STEP_W(STEP_W)) u_tail_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.i_squash_vld),
    .inc_i (tail_inc),
    .ptr_o (tail_ptr)
  );

  // Payload storage is intentionally left unreset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      for (int i = 0; i < INPORT_NUM; i++) begin
        if (bus.i_enq_req[i]) mem_q[tail_idx + IDX_W'(i)] <= bus.i_enq_info[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < OUTPORT_NUM; j++) begin
      deq_req[j]  = (count > CNT_W'(j));
      deq_info[j] = mem_q[head_idx + IDX_W'(j)];
    end
  end

  assign bus.o_can_enq  = can_enq;
  assign bus.o_deq_req  = deq_req;
  assign bus.o_deq_info = deq_info;
  assign bus.o_count    = count;

`ifdef INT_DISPATCH_QUEUE_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Counts rename cycles blocked by a full queue; survives squash, saturates.
  always_comb begin
    perf_d = perf_q;
    if (|bus.i_enq_req && !can_enq && !bus.i_squash_vld && (perf_q != 32'hFFFF_FFFF))
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign o_perf_full_stall = perf_q;
`endif

endmodule

// File: tb/tb_int_dispatch_queue.sv
// Directed bench for int_dispatch_queue: queue-based reference model checked
// every cycle, plus hand-computed literal expectations along the sequence.
module tb_int_dispatch_queue;
  import int_dispatch_queue_pkg::*;

  localparam int DEPTH = INTDQ_SIZE;
  localparam int INP   = RENAME_WIDTH;
  localparam int OUTP  = INTDQ_DISP_WID;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_dispatch_queue_if #(.DEPTH(DEPTH), .INPORT_NUM(INP), .OUTPORT_NUM(OUTP)) bus ();

`ifdef INT_DISPATCH_QUEUE_PERF_EN
  logic [31:0] perf;
`endif

  int_dispatch_queue #(.DEPTH(DEPTH), .INPORT_NUM(INP), .OUTPORT_NUM(OUTP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef INT_DISPATCH_QUEUE_PERF_EN
    ,
    .o_perf_full_stall (perf)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] m_perf = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of payloads updated from the sampled inputs.
  always @(posedge clk) begin
    int  cnt;
    int  ndeq;
    bit  can;
    if (rst) begin
      exp_q.delete();
      m_perf = 32'd0;
    end else begin
      cnt  = exp_q.size();
      can  = (cnt <= DEPTH - INP);
      ndeq = 0;
      for (int j = 0; j < OUTP; j++) begin
        if (j < cnt && bus.i_deq_vld[j]) ndeq++;
        else break;
      end
      if (|bus.i_enq_req && !can && !bus.i_squash_vld && m_perf != 32'hFFFF_FFFF)
        m_perf = m_perf + 32'd1;
      if (bus.i_squash_vld) begin
        exp_q.delete();
      end else begin
        repeat (ndeq) void'(exp_q.pop_front());
        if (can) begin
          for (int i = 0; i < INP; i++)
            if (bus.i_enq_req[i]) exp_q.push_back(32'(bus.i_enq_info[i]));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [OUTP-1:0] exp_req;
    if (chk_en) begin
      for (int j = 0; j < OUTP; j++) exp_req[j] = (j < exp_q.size());
      chk("count", 64'(bus.o_count), 64'(exp_q.size()));
      chk("can_enq", 64'(bus.o_can_enq), 64'(exp_q.size() <= DEPTH - INP));
      chk("deq_req", 64'(bus.o_deq_req), 64'(exp_req));
      for (int j = 0; j < OUTP; j++)
        if (j < exp_q.size()) chk("deq_info", 64'(bus.o_deq_info[j]), 64'(exp_q[j]));
`ifdef INT_DISPATCH_QUEUE_PERF_EN
      chk("perf", 64'(perf), 64'(m_perf));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] req, input int base, input logic [3:0] deq,
                      input logic sq, input logic r);
    @(negedge clk);
    rst              = r;
    bus.i_squash_vld = sq;
    bus.i_enq_req    = req;
    bus.i_deq_vld    = deq;
    for (int i = 0; i < INP; i++)
      bus.i_enq_info[i] = intDQEntry_t'(32'hE000_0000 + 32'(base) + 32'(i));
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.i_squash_vld = 1'b0;
    bus.i_enq_req    = '0;
    bus.i_deq_vld    = '0;
    bus.i_enq_info   = '0;
    step(4'b0000, 0, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 0, 4'b0000, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_can_enq", 64'(bus.o_can_enq), 64'd1);
    chk("rst_deq_req", 64'(bus.o_deq_req), 64'd0);

    step(4'b1111, 'h00, 4'b0000, 1'b0, 1'b0);
    chk("enq4_deq_req", 64'(bus.o_deq_req), 64'hF);
    chk("enq4_count", 64'(bus.o_count), 64'd4);
    chk("enq4_info0", 64'(bus.o_deq_info[0]), 64'hE000_0000);
    chk("enq4_info3", 64'(bus.o_deq_info[3]), 64'hE000_0003);
    step(4'b0000, 0, 4'b0000, 1'b0, 1'b0);
    chk("hold_count", 64'(bus.o_count), 64'd4);

    step(4'b1111, 'h10, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 'h20, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 'h30, 4'b0000, 1'b0, 1'b0);
    chk("full_count", 64'(bus.o_count), 64'd16);
    chk("full_can_enq", 64'(bus.o_can_enq), 64'd0);
    repeat (5) step(4'b0011, 'h40, 4'b0000, 1'b0, 1'b0);
    chk("drop_count", 64'(bus.o_count), 64'd16);
`ifdef INT_DISPATCH_QUEUE_PERF_EN
    chk("perf_5", 64'(perf), 64'd5);
`endif

    // Drain to head index 14, then wrap two new entries into indices 0 and 1.
    step(4'b0000, 0, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 0, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 0, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 0, 4'b0011, 1'b0, 1'b0);
    chk("drain_count", 64'(bus.o_count), 64'd2);
    step(4'b0011, 'h50, 4'b0000, 1'b0, 1'b0);
    chk("wrap_info0", 64'(bus.o_deq_info[0]), 64'hE000_0032);
    chk("wrap_info1", 64'(bus.o_deq_info[1]), 64'hE000_0033);
    chk("wrap_info2", 64'(bus.o_deq_info[2]), 64'hE000_0050);
    chk("wrap_info3", 64'(bus.o_deq_info[3]), 64'hE000_0051);
    step(4'b0000, 0, 4'b1011, 1'b0, 1'b0);
    chk("gap_count", 64'(bus.o_count), 64'd2);
    chk("gap_deq_req", 64'(bus.o_deq_req), 64'h3);
    chk("gap_info0", 64'(bus.o_deq_info[0]), 64'hE000_0050);

    step(4'b1111, 'h60, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 'h70, 4'b0000, 1'b0, 1'b0);
    step(4'b0011, 'h80, 4'b0000, 1'b0, 1'b0);
    chk("c12_count", 64'(bus.o_count), 64'd12);
    step(4'b1111, 'h90, 4'b0111, 1'b0, 1'b0);
    chk("both_count", 64'(bus.o_count), 64'd13);
    chk("both_info0", 64'(bus.o_deq_info[0]), 64'hE000_0061);
    step(4'b0000, 0, 4'b1111, 1'b0, 1'b0);
    chk("c9_count", 64'(bus.o_count), 64'd9);
    chk("c9_info0", 64'(bus.o_deq_info[0]), 64'hE000_0071);

    step(4'b1111, 'hA0, 4'b1111, 1'b1, 1'b0);
    chk("sq_count", 64'(bus.o_count), 64'd0);
    chk("sq_deq_req", 64'(bus.o_deq_req), 64'd0);
    chk("sq_can_enq", 64'(bus.o_can_enq), 64'd1);
`ifdef INT_DISPATCH_QUEUE_PERF_EN
    chk("perf_after_sq", 64'(perf), 64'd5);
`endif
    step(4'b0001, 'hB0, 4'b0000, 1'b0, 1'b0);
    chk("post_sq_deq_req", 64'(bus.o_deq_req), 64'h1);
    chk("post_sq_info0", 64'(bus.o_deq_info[0]), 64'hE000_00B0);

    step(4'b1111, 'hC0, 4'b1101, 1'b0, 1'b0);
    chk("prefix_count", 64'(bus.o_count), 64'd4);
    chk("prefix_info0", 64'(bus.o_deq_info[0]), 64'hE000_00C0);
    step(4'b0000, 0, 4'b0110, 1'b0, 1'b0);
    chk("lead0_count", 64'(bus.o_count), 64'd4);
    step(4'b0000, 0, 4'b0111, 1'b0, 1'b0);
    chk("deq3_count", 64'(bus.o_count), 64'd1);
    chk("deq3_info0", 64'(bus.o_deq_info[0]), 64'hE000_00C3);

    step(4'b0111, 'hD0, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 'hF0, 4'b1111, 1'b1, 1'b1);
    chk("midrst_count", 64'(bus.o_count), 64'd0);
    chk("midrst_can_enq", 64'(bus.o_can_enq), 64'd1);
`ifdef INT_DISPATCH_QUEUE_PERF_EN
    chk("perf_after_rst", 64'(perf), 64'd0);
`endif
    step(4'b1111, 'hE0, 4'b0000, 1'b0, 1'b0);
    chk("after_rst_info0", 64'(bus.o_deq_info[0]), 64'hE000_00E0);
    chk("after_rst_count", 64'(bus.o_count), 64'd4);
    step(4'b0000, 0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
